// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package rf_ctrl_pkg;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LSU    = 1;
    localparam int REQ_MULDIV = 2;
    localparam int NUM_REQ    = 3;

    localparam int XLEN    = 32;
    localparam int RD_W    = 5;
    localparam int RF_REGS = 32;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the pointer, wrapping N-1 -> 0; the pointer moves past the winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] valid_i,
    output logic [N-1:0] grant_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        sum     = '0;
        idx     = '0;
        found   = 1'b0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = (idx == PTR_W'(N-1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the register file write port among writeback sources and tracks
// in-flight writes per architectural register for decode RAW stalls.
module rf_wb_scheduler #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*5-1:0]    req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0] req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic                    issue_valid_i,
    input  logic [4:0]              issue_rd_i,
    output logic                    issue_ready_o,
    output logic [31:0]             busy_o,
    output logic [4:0]              rd_o,
    output logic [XLEN-1:0]         rd_din_o,
    output logic                    reg_write_o
);

    import rf_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [RD_W-1:0]    win_rd;
    logic [XLEN-1:0]    win_data;
    logic               issue_fire;
    logic [CNT_W-1:0]   cnt_w [RF_REGS];

    logic [RD_W-1:0]    rd_q;
    logic [XLEN-1:0]    din_q;
    logic               we_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (req_valid_i),
        .grant_o (grant)
    );

    assign req_ready_o = grant;
    assign xfer        = |grant;

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                win_rd   = req_rd_i[5*k +: 5];
                win_data = req_data_i[XLEN*k +: XLEN];
            end
        end
    end

    assign issue_ready_o = (issue_rd_i == '0) || (cnt_w[issue_rd_i] != CNT_MAX);
    assign issue_fire    = issue_valid_i && issue_ready_o;

    // x0 has no counter: it is never busy and issues to it never count.
    assign cnt_w[0]  = '0;
    assign busy_o[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < RF_REGS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic             inc;
            logic             dec;

            assign inc = issue_fire && (issue_rd_i == RD_W'(gi));
            assign dec = xfer && (win_rd == RD_W'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (inc && !dec) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (dec && !inc && (cnt_q != '0)) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            // A retire with nothing outstanding means a requester lied.
            always_ff @(posedge clk_i) begin
                if (!rst_i && dec && !inc) begin
                    assert (cnt_q != '0);
                end
            end

            assign cnt_w[gi]  = cnt_q;
            assign busy_o[gi] = (cnt_q != '0);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            din_q <= '0;
            we_q  <= 1'b0;
        end else if (xfer) begin
            rd_q  <= win_rd;
            din_q <= win_data;
            we_q  <= (win_rd != '0);
        end else begin
            we_q  <= 1'b0;
        end
    end

    assign rd_o        = rd_q;
    assign rd_din_o    = din_q;
    assign reg_write_o = we_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomized and directed bench for rf_wb_scheduler against a behavioural model.
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready_o;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready_o;
    logic [31:0] busy_o;
    logic [4:0]  rd_o;
    logic [31:0] rd_din_o;
    logic        reg_write_o;

    int errs   = 0;
    int checks = 0;

    // Behavioural model state
    int          cnt_m [32];
    int          pres  [32];
    int          ptr_m;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_din;

    always #5 clk = ~clk;

    rf_wb_scheduler #(.XLEN(32), .NUM_REQ(3), .CNT_W(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid),
        .req_rd_i      (req_rd),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready_o),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready_o),
        .busy_o        (busy_o),
        .rd_o          (rd_o),
        .rd_din_o      (rd_din_o),
        .reg_write_o   (reg_write_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            cnt_m[r] = 0;
            pres[r]  = 0;
        end
        ptr_m   = 0;
        exp_we  = 1'b0;
        exp_rd  = '0;
        exp_din = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic step(output int g);
        logic [2:0]  exp_rdy;
        logic        exp_iss;
        logic [31:0] exp_busy;
        logic [4:0]  grd;
        logic        inc;
        logic        dec;
        int          k;
        @(negedge clk);
        g = -1;
        for (int off = 0; off < 3; off++) begin
            k = (ptr_m + off) % 3;
            if (g < 0 && req_valid[k]) g = k;
        end
        exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        exp_iss = (issue_rd == 0) || (cnt_m[issue_rd] != 3);
        exp_busy = '0;
        for (int r = 1; r < 32; r++) exp_busy[r] = (cnt_m[r] != 0);
        check("ready", 64'(req_ready_o), 64'(exp_rdy));
        check("issue_ready", 64'(issue_ready_o), 64'(exp_iss));
        check("busy", 64'(busy_o), 64'(exp_busy));
        check("reg_write", 64'(reg_write_o), 64'(exp_we));
        if (exp_we) begin
            check("rd", 64'(rd_o), 64'(exp_rd));
            check("rd_din", 64'(rd_din_o), 64'(exp_din));
        end
        $display("cyc t=%0t rst=%0b vld=%b rdy=%b iss=%0b/%0d we=%0b rd=%0d din=%h busy=%h",
                 $time, rst_i, req_valid, req_ready_o, issue_valid, issue_rd,
                 reg_write_o, rd_o, rd_din_o, busy_o);
        if (rst_i) begin
            model_reset();
            g = -1;
        end else begin
            grd = (g >= 0) ? req_rd[5*g +: 5] : 5'd0;
            if (g >= 0) begin
                exp_we = (grd != 0);
                if (grd != 0) begin
                    exp_rd  = grd;
                    exp_din = req_data[32*g +: 32];
                end
                ptr_m = (g + 1) % 3;
            end else begin
                exp_we = 1'b0;
            end
            for (int r = 1; r < 32; r++) begin
                inc = issue_valid && exp_iss && (issue_rd == 5'(r));
                dec = (g >= 0) && (grd == 5'(r));
                if (inc && dec) begin
                end else if (inc) cnt_m[r]++;
                else if (dec && cnt_m[r] > 0) cnt_m[r]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        int g;
        int r;
        int t2_exp;
        clear_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();

        // 1: idle after reset
        step(g);
        check("t1_rd_o", 64'(rd_o), 64'd0);
        check("t1_din_o", 64'(rd_din_o), 64'd0);
        check("t1_issue_ready", 64'(issue_ready_o), 64'd1);

        // 3: issue rd=9, LSU retires it
        issue_valid = 1'b1; issue_rd = 5'd9;
        step(g);
        clear_inputs();
        step(g);
        check("t3_busy9", 64'(busy_o[9]), 64'd1);
        req_valid = 3'b010; req_rd[5 +: 5] = 5'd9; req_data[32 +: 32] = 32'hDEADBEEF;
        step(g);
        clear_inputs();
        step(g);
        check("t3_rd", 64'(rd_o), 64'd9);
        check("t3_din", 64'(rd_din_o), 64'hDEADBEEF);
        check("t3_we", 64'(reg_write_o), 64'd0);
        check("t3_busy9_clr", 64'(busy_o[9]), 64'd0);

        // 4: saturate rd=3
        issue_valid = 1'b1; issue_rd = 5'd3;
        repeat (3) step(g);
        issue_valid = 1'b0;
        #1 check("t4_sat3", 64'(issue_ready_o), 64'd0);
        step(g);
        issue_rd = 5'd4;
        #1 check("t4_rd4", 64'(issue_ready_o), 64'd1);
        step(g);
        issue_rd = 5'd3;
        req_valid = 3'b001; req_rd[4:0] = 5'd3; req_data[31:0] = 32'h1234_5678;
        step(g);
        req_valid = '0;
        #1 check("t4_unsat3", 64'(issue_ready_o), 64'd1);
        step(g);

        // 5: simultaneous issue and retire of rd=12
        issue_valid = 1'b1; issue_rd = 5'd12;
        step(g);
        req_valid = 3'b001; req_rd[4:0] = 5'd12; req_data[31:0] = 32'h0000_0C0C;
        step(g);
        clear_inputs();
        step(g);
        check("t5_busy12", 64'(busy_o[12]), 64'd1);
        req_valid = 3'b100; req_rd[10 +: 5] = 5'd12; req_data[64 +: 32] = 32'h5555_AAAA;
        step(g);
        clear_inputs();
        step(g);

        // 6a: ALU write to x0
        req_valid = 3'b001; req_rd[4:0] = 5'd0; req_data[31:0] = 32'hFFFF_FFFF;
        #1 check("t6_ready0", 64'(req_ready_o), 64'd1);
        step(g);
        clear_inputs();
        #1 check("t6_we0", 64'(reg_write_o), 64'd0);
        check("t6_busy0", 64'(busy_o[0]), 64'd0);
        step(g);

        // Random traffic with requests kept legal against outstanding issues
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!req_valid[k] && ($urandom_range(0, 1) == 1)) begin
                    r = 0;
                    if ($urandom_range(0, 4) != 0) begin
                        for (int t = 0; t < 8 && r == 0; t++) begin
                            int cand;
                            cand = $urandom_range(1, 7);
                            if (cnt_m[cand] - pres[cand] > 0) r = cand;
                        end
                    end
                    if (r != 0) pres[r]++;
                    req_valid[k]        = 1'b1;
                    req_rd[5*k +: 5]    = 5'(r);
                    req_data[32*k +: 32] = $urandom;
                end
            end
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom_range(0, 7));
            step(g);
            if (g >= 0) begin
                r = int'(req_rd[5*g +: 5]);
                if (r != 0) pres[r]--;
                req_valid[g] = 1'b0;
            end
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 6 && req_valid != 0; c++) begin
            step(g);
            if (g >= 0) begin
                r = int'(req_rd[5*g +: 5]);
                if (r != 0) pres[r]--;
                req_valid[g] = 1'b0;
            end
        end
        check("drain_done", 64'(req_valid), 64'd0);

        // 2: all three valid every cycle, issue tracks the expected winner
        req_valid = 3'b111;
        req_rd    = {5'd7, 5'd6, 5'd5};
        req_data  = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005};
        issue_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            t2_exp   = ptr_m;
            issue_rd = 5'(5 + t2_exp);
            step(g);
            check("t2_grant", 64'(g), 64'(t2_exp));
            #1 check("t2_rd", 64'(rd_o), 64'(5 + t2_exp));
            check("t2_we", 64'(reg_write_o), 64'd1);
        end

        // 6b: reset in the middle of the burst
        rst_i = 1'b1;
        step(g);
        rst_i = 1'b0;
        clear_inputs();
        #1 check("t6_rst_we", 64'(reg_write_o), 64'd0);
        check("t6_rst_rd", 64'(rd_o), 64'd0);
        check("t6_rst_din", 64'(rd_din_o), 64'd0);
        check("t6_rst_busy", 64'(busy_o), 64'd0);
        step(g);
        step(g);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
